// File: rtl/agc_sim_pkg.sv
// Shared timing definitions for the AGC simulation sequencer: FSM encoding,
// MCT geometry and the one-hot start positions of the timepulse/phase rings.
package agc_sim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } seq_state_e;

    localparam int TP_COUNT = 12;
    localparam int PH_COUNT = 4;

    localparam logic [TP_COUNT-1:0] T01 = 12'h001;
    localparam logic [PH_COUNT-1:0] PH1 = 4'b0001;

    // A settle count of 1 would still need a one-bit register.
    function automatic int settle_cnt_width(input int settle_cycles);
        return (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
    endfunction

endpackage

// File: rtl/agc_settle_counter.sv
// Counts SIM_CLK cycles within one phase; tc marks the last cycle of the phase
// so the sequencer can advance on that edge.
module agc_settle_counter
    import agc_sim_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8
) (
    input  logic SIM_CLK,
    input  logic SIM_RST,
    input  logic en,
    output logic tc
);

    localparam int CW = settle_cnt_width(SETTLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

    generate
        if (SETTLE_CYCLES < 2) begin : g_bad_settle
            $error("agc_settle_counter: SETTLE_CYCLES must be >= 2");
        end
    endgenerate

    logic [CW-1:0] count;

    assign tc = en && (count == LAST);

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/agc_timepulse_sequencer.sv
// Generates the one-hot T01..T12 timepulses and PH1..PH4 phases for the AGC
// gate netlist, with run / single-MCT step / graceful stop control.
module agc_timepulse_sequencer #(
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                              SIM_CLK,
    input  logic                              SIM_RST,
    input  logic                              RUN,
    input  logic                              STEP,
    output logic [agc_sim_pkg::TP_COUNT-1:0]  T,
    output logic [agc_sim_pkg::PH_COUNT-1:0]  PH,
    output logic                              ADV,
    output logic                              MCT_END,
    output logic                              HALTED,
    output logic [1:0]                        DBG_STATE
);

    import agc_sim_pkg::*;

    localparam logic [1:0] S_IDLE  = agc_sim_pkg::IDLE;
    localparam logic [1:0] S_RUN   = agc_sim_pkg::RUN;
    localparam logic [1:0] S_DRAIN = agc_sim_pkg::DRAIN;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       counting;
    logic       tc;
    logic       wrap;

    assign counting  = (state != S_IDLE);
    assign wrap      = tc && PH[PH_COUNT-1] && T[TP_COUNT-1];
    assign DBG_STATE = state;

    agc_settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .SIM_CLK(SIM_CLK),
        .SIM_RST(SIM_RST),
        .en     (counting),
        .tc     (tc)
    );

    // A stop request never truncates an MCT: leaving RUN/DRAIN only happens
    // on the wrap edge, so halts always land on T01/PH1 with the counter at 0.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (RUN) begin
                    state_nxt = S_RUN;
                end else if (STEP) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_RUN: begin
                if (wrap) begin
                    state_nxt = RUN ? S_RUN : S_IDLE;
                end else if (!RUN) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (wrap) begin
                    state_nxt = S_IDLE;
                end else if (RUN) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state   <= S_IDLE;
            T       <= T01;
            PH      <= PH1;
            ADV     <= 1'b0;
            MCT_END <= 1'b0;
            HALTED  <= 1'b1;
        end else begin
            state   <= state_nxt;
            ADV     <= tc;
            MCT_END <= wrap;
            HALTED  <= (state_nxt == S_IDLE);
            if (tc) begin
                PH <= {PH[PH_COUNT-2:0], PH[PH_COUNT-1]};
                if (PH[PH_COUNT-1]) begin
                    T <= {T[TP_COUNT-2:0], T[TP_COUNT-1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_agc_timepulse_sequencer.sv
// Self-checking bench: every ADV/MCT_END event is matched against a queue of
// expected (cycle, T, PH, MCT_END) tuples computed from the MCT geometry.
module tb_agc_timepulse_sequencer;

  logic        SIM_CLK = 1'b0;
  logic        SIM_RST = 1'b1;
  logic        RUN = 1'b0, STEP = 1'b0;
  logic        RUN_b = 1'b0, STEP_b = 1'b0;
  logic [11:0] T, T_b;
  logic [3:0]  PH, PH_b;
  logic        ADV, MCT_END, HALTED;
  logic        ADV_b, MCT_END_b, HALTED_b;
  logic [1:0]  DBG_STATE, DBG_STATE_b;

  logic [31:0] cyc = 32'd0;
  int          n_total = 0;
  int          n_pass = 0;
  logic [48:0] exp_q[$];
  logic [48:0] exp_b_q[$];
  logic [48:0] mon_e, mon_b_e;

  agc_timepulse_sequencer #(.SETTLE_CYCLES(8)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .RUN(RUN), .STEP(STEP),
    .T(T), .PH(PH), .ADV(ADV), .MCT_END(MCT_END), .HALTED(HALTED),
    .DBG_STATE(DBG_STATE)
  );

  agc_timepulse_sequencer #(.SETTLE_CYCLES(2)) dut_b (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .RUN(RUN_b), .STEP(STEP_b),
    .T(T_b), .PH(PH_b), .ADV(ADV_b), .MCT_END(MCT_END_b), .HALTED(HALTED_b),
    .DBG_STATE(DBG_STATE_b)
  );

  // ---------------- clock / reset ----------------
  always #5 SIM_CLK = ~SIM_CLK;
  always @(posedge SIM_CLK) cyc <= cyc + 32'd1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit (cyc=%0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // n-th advance after the start edge: PH and T positions follow from n alone.
  function automatic logic [48:0] adv_entry(input logic [31:0] c0, input int n, input int s);
    logic [3:0]  ph;
    logic [11:0] tp;
    logic [3:0]  ph1;
    logic [11:0] t01;
    ph1 = 4'b0001;
    t01 = 12'h001;
    ph  = ph1 << (n % 4);
    tp  = t01 << ((n / 4) % 12);
    return {c0 + 32'(1 + s * n), tp, ph, ((n % 48) == 0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_range(input logic [31:0] c0, input int n_from, input int n_to,
                            input int s, input bit to_b);
    for (int n = n_from; n <= n_to; n++) begin
      if (to_b) exp_b_q.push_back(adv_entry(c0, n, s));
      else      exp_q.push_back(adv_entry(c0, n, s));
    end
  endtask

  task automatic wait_until(input logic [31:0] t);
    while (cyc < t) @(negedge SIM_CLK);
  endtask

  // ---------------- scoreboards ----------------
  always @(negedge SIM_CLK) begin
    if (SIM_RST && (ADV || MCT_END)) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL adv_unexpected: cyc=%0d T=%h PH=%b MCT_END=%b, no event expected",
                 cyc, T, PH, MCT_END);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ADV, cyc, T, PH, MCT_END} !== {1'b1, mon_e})
          $display("FAIL adv_event: got ADV=%b cyc=%0d T=%h PH=%b MCT_END=%b, expected cyc=%0d T=%h PH=%b MCT_END=%b",
                   ADV, cyc, T, PH, MCT_END, mon_e[48:17], mon_e[16:5], mon_e[4:1], mon_e[0]);
        else n_pass++;
      end
    end
  end

  always @(negedge SIM_CLK) begin
    if (SIM_RST && (ADV_b || MCT_END_b)) begin
      n_total++;
      if (exp_b_q.size() == 0) begin
        $display("FAIL adv_b_unexpected: cyc=%0d T=%h PH=%b MCT_END=%b, no event expected",
                 cyc, T_b, PH_b, MCT_END_b);
      end else begin
        mon_b_e = exp_b_q.pop_front();
        if ({ADV_b, cyc, T_b, PH_b, MCT_END_b} !== {1'b1, mon_b_e})
          $display("FAIL adv_b_event: got ADV=%b cyc=%0d T=%h PH=%b MCT_END=%b, expected cyc=%0d T=%h PH=%b MCT_END=%b",
                   ADV_b, cyc, T_b, PH_b, MCT_END_b, mon_b_e[48:17], mon_b_e[16:5], mon_b_e[4:1], mon_b_e[0]);
        else n_pass++;
      end
    end
  end

  // ---------------- tests ----------------
  logic [31:0] g_c0;

  task automatic test_reset;
    logic [31:0] c0;
    #1 SIM_RST = 1'b0;
    #2;
    n_total++; if (T !== 12'h001)     $display("FAIL por_T: got %h expected 001", T); else n_pass++;
    n_total++; if (PH !== 4'b0001)    $display("FAIL por_PH: got %b expected 0001", PH); else n_pass++;
    n_total++; if (HALTED !== 1'b1)   $display("FAIL por_HALTED: got %b expected 1", HALTED); else n_pass++;
    n_total++; if ({ADV, MCT_END} !== 2'b00)
      $display("FAIL por_strobes: got ADV=%b MCT_END=%b expected 0 0", ADV, MCT_END); else n_pass++;
    @(negedge SIM_CLK);
    SIM_RST = 1'b1;
    // run into T07/PH3, then reset between clock edges
    @(negedge SIM_CLK);
    c0 = cyc;
    push_range(c0, 1, 26, 8, 1'b0);
    RUN = 1'b1;
    wait_until(c0 + 32'd1 + 32'd208 + 32'd3);
    #2 SIM_RST = 1'b0;
    #1;
    n_total++; if (T !== 12'h001)     $display("FAIL rst_mid_T: got %h expected 001", T); else n_pass++;
    n_total++; if (PH !== 4'b0001)    $display("FAIL rst_mid_PH: got %b expected 0001", PH); else n_pass++;
    n_total++; if (HALTED !== 1'b1)   $display("FAIL rst_mid_HALTED: got %b expected 1", HALTED); else n_pass++;
    n_total++; if ({ADV, MCT_END} !== 2'b00)
      $display("FAIL rst_mid_strobes: got ADV=%b MCT_END=%b expected 0 0", ADV, MCT_END); else n_pass++;
    n_total++; if (DBG_STATE !== 2'b00) $display("FAIL rst_mid_state: got %b expected 00", DBG_STATE); else n_pass++;
    n_total++; if (exp_q.size() != 0)
      $display("FAIL rst_mid_events: got %0d pending expected 0", exp_q.size()); else n_pass++;
    RUN = 1'b0;
    @(negedge SIM_CLK);
    SIM_RST = 1'b1;
    repeat (3) @(negedge SIM_CLK);
  endtask

  task automatic test_run;
    bit halt_seen;
    halt_seen = 1'b0;
    @(negedge SIM_CLK);
    g_c0 = cyc;
    push_range(g_c0, 1, 112, 8, 1'b0);
    RUN = 1'b1;
    @(negedge SIM_CLK);
    while (cyc < g_c0 + 32'd1 + 32'd8 * 32'd112) begin
      if (HALTED !== 1'b0) halt_seen = 1'b1;
      @(negedge SIM_CLK);
    end
    #1;
    n_total++; if (halt_seen !== 1'b0) $display("FAIL run_halted: got HALTED seen=1 expected 0"); else n_pass++;
    n_total++; if (exp_q.size() != 0)
      $display("FAIL run_events: got %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_graceful_stop;
    RUN = 1'b0;
    push_range(g_c0, 113, 144, 8, 1'b0);
    wait_until(g_c0 + 32'd1 + 32'd8 * 32'd144 + 32'd1);
    n_total++; if (HALTED !== 1'b1) $display("FAIL stop_HALTED: got %b expected 1", HALTED); else n_pass++;
    n_total++; if ({T, PH} !== {12'h001, 4'b0001})
      $display("FAIL stop_pos: got T=%h PH=%b expected 001 0001", T, PH); else n_pass++;
    n_total++; if (DBG_STATE !== 2'b00) $display("FAIL stop_state: got %b expected 00", DBG_STATE); else n_pass++;
    n_total++; if (exp_q.size() != 0)
      $display("FAIL stop_events: got %0d pending expected 0", exp_q.size()); else n_pass++;
    repeat (16) @(negedge SIM_CLK);
    n_total++; if ({T, PH, HALTED} !== {12'h001, 4'b0001, 1'b1})
      $display("FAIL stop_hold: got T=%h PH=%b HALTED=%b expected 001 0001 1", T, PH, HALTED); else n_pass++;
  endtask

  task automatic test_single_step;
    logic [31:0] c0;
    @(negedge SIM_CLK);
    c0 = cyc;
    push_range(c0, 1, 48, 8, 1'b0);
    STEP = 1'b1;
    @(negedge SIM_CLK);
    STEP = 1'b0;
    n_total++; if (HALTED !== 1'b0) $display("FAIL step_start_HALTED: got %b expected 0", HALTED); else n_pass++;
    n_total++; if (DBG_STATE !== 2'b10) $display("FAIL step_state: got %b expected 10", DBG_STATE); else n_pass++;
    wait_until(c0 + 32'd1 + 32'd384 + 32'd1);
    n_total++; if (HALTED !== 1'b1) $display("FAIL step_end_HALTED: got %b expected 1", HALTED); else n_pass++;
    n_total++; if (exp_q.size() != 0)
      $display("FAIL step_events: got %0d pending expected 0", exp_q.size()); else n_pass++;
    repeat (20) @(negedge SIM_CLK);
    n_total++; if ({T, PH, HALTED} !== {12'h001, 4'b0001, 1'b1})
      $display("FAIL step_hold: got T=%h PH=%b HALTED=%b expected 001 0001 1", T, PH, HALTED); else n_pass++;
  endtask

  task automatic test_rearm;
    logic [31:0] c0;
    bit halt_seen;
    halt_seen = 1'b0;
    @(negedge SIM_CLK);
    c0 = cyc;
    push_range(c0, 1, 96, 8, 1'b0);
    RUN = 1'b1;
    @(negedge SIM_CLK);
    while (cyc < c0 + 32'd1 + 32'd768) begin
      if (cyc == c0 + 32'd1 + 32'd64)  RUN = 1'b0;
      if (cyc == c0 + 32'd1 + 32'd256) RUN = 1'b1;
      if (cyc == c0 + 32'd1 + 32'd480) RUN = 1'b0;
      if (HALTED !== 1'b0) halt_seen = 1'b1;
      @(negedge SIM_CLK);
    end
    @(negedge SIM_CLK);
    n_total++; if (halt_seen !== 1'b0) $display("FAIL rearm_halted: got HALTED seen=1 expected 0"); else n_pass++;
    n_total++; if (HALTED !== 1'b1) $display("FAIL rearm_end_HALTED: got %b expected 1", HALTED); else n_pass++;
    n_total++; if (exp_q.size() != 0)
      $display("FAIL rearm_events: got %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_priority;
    logic [31:0] c0;
    @(negedge SIM_CLK);
    c0 = cyc;
    push_range(c0, 1, 96, 2, 1'b1);
    RUN_b  = 1'b1;
    STEP_b = 1'b1;
    @(negedge SIM_CLK);
    STEP_b = 1'b0;
    n_total++; if (DBG_STATE_b !== 2'b01) $display("FAIL prio_state: got %b expected 01", DBG_STATE_b); else n_pass++;
    n_total++; if (HALTED_b !== 1'b0) $display("FAIL prio_HALTED: got %b expected 0", HALTED_b); else n_pass++;
    while (cyc < c0 + 32'd1 + 32'd192) begin
      if (cyc == c0 + 32'd1 + 32'd120) RUN_b = 1'b0;
      STEP_b = ($urandom_range(0, 5) == 0);
      @(negedge SIM_CLK);
    end
    STEP_b = 1'b0;
    @(negedge SIM_CLK);
    n_total++; if (HALTED_b !== 1'b1) $display("FAIL prio_end_HALTED: got %b expected 1", HALTED_b); else n_pass++;
    n_total++; if ({T_b, PH_b} !== {12'h001, 4'b0001})
      $display("FAIL prio_end_pos: got T=%h PH=%b expected 001 0001", T_b, PH_b); else n_pass++;
    n_total++; if (exp_b_q.size() != 0)
      $display("FAIL prio_events: got %0d pending expected 0", exp_b_q.size()); else n_pass++;
    repeat (8) @(negedge SIM_CLK);
    n_total++; if ({T_b, PH_b, HALTED_b} !== {12'h001, 4'b0001, 1'b1})
      $display("FAIL prio_hold: got T=%h PH=%b HALTED=%b expected 001 0001 1", T_b, PH_b, HALTED_b); else n_pass++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset;
    test_run;
    test_graceful_stop;
    test_single_step;
    test_rearm;
    test_priority;
    repeat (4) @(negedge SIM_CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
